// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: read-priority access to a single-port pixel RAM with
// write anti-starvation, a 2-cycle read return path and an end-of-frame pulse.
module fb_arbiter #(
  parameter int                DATA_W     = 15,
  parameter int                ADDR_W     = 20,
  parameter int                STARVE_MAX = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'({10'd479, 10'd639})
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              frame_done
);

  typedef enum logic {FILLING, FRAME_END} frame_st_e;

  logic [7:0]        starve_q, starve_d;
  logic [1:0]        vld_pipe_q;
  logic [DATA_W-1:0] rd_data_q;
  frame_st_e         st_q;
  logic              frame_done_q;
  logic              live, starved;

  // Grants are gated by reset too, so nothing reaches the RAM while held in reset.
  assign live    = rst & en;
  assign starved = (starve_q == 8'(STARVE_MAX));

  always_comb begin
    wr_ready = live & wr_req & (~rd_req | starved);
    rd_ready = live & rd_req & ~wr_ready;
    ram_en   = wr_ready | rd_ready;
    ram_we   = wr_ready;
    ram_addr = '0;
    ram_din  = '0;
    if (wr_ready) begin
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end else if (rd_ready) begin
      ram_addr = rd_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (en) begin
      if (!wr_req || wr_ready) starve_d = '0;
      else if (!starved)       starve_d = starve_q + 8'd1;
    end
  end

  // Stage 0 marks the RAM cycle, stage 1 is the returned data slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q   <= '0;
      vld_pipe_q <= '0;
      rd_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      vld_pipe_q <= {vld_pipe_q[0], rd_ready};
      if (vld_pipe_q[0]) rd_data_q <= ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= FILLING;
      frame_done_q <= 1'b0;
    end else begin
      case (st_q)
        FILLING: if (wr_ready && wr_addr == LAST_ADDR) begin
          st_q         <= FRAME_END;
          frame_done_q <= 1'b1;
        end
        default: begin
          st_q         <= FILLING;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid   = vld_pipe_q[1];
  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboarded random + directed bench for fb_arbiter against a cycle-level reference model.
module tb_fb_arbiter;
  localparam int          STARVE = 8;
  localparam logic [19:0] LAST   = {10'd479, 10'd639};
  localparam logic [19:0] NLAST  = {10'd479, 10'd638};

  logic        clk = 1'b0;
  logic        rst, en, wr_req, rd_req;
  logic [19:0] wr_addr, rd_addr, ram_addr;
  logic [14:0] wr_data, ram_dout, rd_data, ram_din;
  logic        wr_ready, rd_ready, rd_valid, ram_en, ram_we, frame_done;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [14:0] data; } rexp_t;
  rexp_t       rq[$];
  int          fq[$];
  int          checks = 0, errors = 0, cyc_n = 0;
  int          m_starve = 0;
  bit          m_prev_rd = 0, m_frame_end = 0, started = 0;
  logic [14:0] last_data = '0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc_n);
    end
  endtask

  // One bus cycle: drive after the edge, compare grant/RAM outputs mid-cycle, advance the model.
  task automatic cyc(input bit r, input bit e, input bit w, input logic [19:0] wa,
                     input logic [14:0] wd, input bit rr, input logic [19:0] ra,
                     input logic [14:0] dout);
    bit ew, er;
    @(posedge clk); #1;
    rst = r; en = e; wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = rr; rd_addr = ra; ram_dout = dout;
    if (!r) begin
      m_prev_rd = 0; m_starve = 0; m_frame_end = 0; last_data = '0;
      rq.delete(); fq.delete();
    end else if (m_prev_rd) begin
      rq.push_back('{cyc_n + 1, dout});
    end
    @(negedge clk);
    ew = 0; er = 0;
    if (r && e) begin
      if (w && rr) begin
        if (m_starve >= STARVE) ew = 1; else er = 1;
      end else begin
        ew = w; er = rr;
      end
    end
    chk("wr_ready", wr_ready, ew);
    chk("rd_ready", rd_ready, er);
    chk("ram_en",   ram_en,   ew | er);
    chk("ram_we",   ram_we,   ew);
    chk("ram_addr", ram_addr, ew ? wa : (er ? ra : 20'd0));
    chk("ram_din",  ram_din,  ew ? wd : 15'd0);
    m_prev_rd = er;
    if (!r)     m_starve = 0;
    else if (e) m_starve = (!w || ew) ? 0 : ((m_starve < STARVE) ? m_starve + 1 : m_starve);
    if (!m_frame_end && ew && wa == LAST) begin
      m_frame_end = 1;
      fq.push_back(cyc_n + 1);
    end else m_frame_end = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, '0, '0, 0, '0, 15'(i));
  endtask

  always @(negedge clk) if (started) begin
    rexp_t re;
    if (rd_valid) begin
      if (rq.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rd_latency", cyc_n, re.cyc);
        chk("rd_data", rd_data, re.data);
        last_data = re.data;
      end
    end else begin
      chk("rd_data_hold", rd_data, last_data);
      if (rq.size() > 0 && rq[0].cyc <= cyc_n) begin
        chk("rd_valid_missing", 0, 1);
        void'(rq.pop_front());
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) chk("frame_done_unexpected", 1, 0);
      else chk("frame_done_cycle", cyc_n, fq.pop_front());
    end else if (fq.size() > 0 && fq[0] <= cyc_n) begin
      chk("frame_done_missing", 0, 1);
      void'(fq.pop_front());
    end
  end

  initial begin
    rst = 0; en = 0; wr_req = 0; rd_req = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; ram_dout = '0;
    started = 1;
    // Reset: requests present but nothing may be granted.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 20'h3, 15'h7, 1, 20'h4, 15'h55);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_frame_done", frame_done, 0);
    idle(2);

    // Single read with fixed RAM data.
    cyc(1, 1, 0, '0, '0, 1, 20'h00005, 15'h0);
    chk("single_rd_ready", rd_ready, 1);
    cyc(1, 1, 0, '0, '0, 0, '0, 15'h1234);
    cyc(1, 1, 0, '0, '0, 0, '0, 15'h0);
    chk("single_rd_valid", rd_valid, 1);
    chk("single_rd_data", rd_data, 15'h1234);
    idle(2);

    // Contention: write forced through after STARVE_MAX denied cycles.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 1, 20'h100 + 20'(i), 15'h300 + 15'(i), 1, 20'h200 + 20'(i), 15'h40 + 15'(i));
      chk("contention_wr", wr_ready, i == 8);
      chk("contention_rd", rd_ready, i != 8);
    end
    idle(3);

    // Frame end pulse on LAST only.
    cyc(1, 1, 1, LAST, 15'h7FFF, 0, '0, '0);
    cyc(1, 1, 0, '0, '0, 0, '0, '0);
    chk("frame_pulse", frame_done, 1);
    cyc(1, 1, 0, '0, '0, 0, '0, '0);
    chk("frame_pulse_width", frame_done, 0);
    cyc(1, 1, 1, NLAST, 15'h1, 0, '0, '0);
    cyc(1, 1, 0, '0, '0, 0, '0, '0);
    chk("frame_not_last", frame_done, 0);
    idle(2);

    // Enable gating with a read still in flight; starvation count must hold.
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 20'h11, 15'h22, 1, 20'h7, 15'(i));
    for (int j = 0; j < 5; j++) begin
      cyc(1, 0, 1, 20'h11, 15'h22, 1, 20'h7, (j == 0) ? 15'h2AA : 15'h0);
      if (j == 1) begin
        chk("gated_rd_valid", rd_valid, 1);
        chk("gated_rd_data", rd_data, 15'h2AA);
      end
    end
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 20'h11, 15'h22, 1, 20'h7, 15'h10 + 15'(i));
    idle(3);

    // Reset while a read is in flight.
    cyc(1, 1, 0, '0, '0, 1, 20'h9, 15'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, '0, '0, 0, '0, 15'h5A5);
      chk("rst_mid_rd_valid", rd_valid, 0);
    end
    idle(3);

    // Streaming back-to-back reads.
    for (int i = 0; i < 13; i++) cyc(1, 1, 0, '0, '0, i < 10, 20'(i), 15'h100 + 15'(i));
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit          r = ($urandom_range(0, 99) != 0);
      bit          e = ($urandom_range(0, 9) != 0);
      logic [19:0] wa = ($urandom_range(0, 7) == 0) ? LAST : 20'($urandom);
      cyc(r, e, 1'($urandom), wa, 15'($urandom), 1'($urandom), 20'($urandom), 15'($urandom));
    end
    idle(4);
    chk("rd_queue_empty", rq.size(), 0);
    chk("frame_queue_empty", fq.size(), 0);
    started = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
